// File: rtl/hazard_unit.sv
// hazard_unit: RV32I 5-stage load-use/RAW stall, branch flush, freeze and E-stage forwarding control.
// HAZARD_FWD_EN defined: forwarding present and only load-use stalls; undefined: fwd selects tied 00.
`default_nettype none

module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr_D,
   input  logic             valid_D,
   input  logic             br_taken_E,
   input  logic             mem_busy,
   output logic             stall_F,
   output logic             stall_D,
   output logic             flush_D,
   output logic             flush_E,
   output logic             freeze,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
   } stage_t;

   // x0 never creates a dependence: wr/use bits are only set for non-zero registers
   function automatic stage_t decode(input logic [31:0] ins, input logic v);
      stage_t     s;
      logic [6:0] op;
      op     = ins[6:0];
      s      = '0;
      s.rd   = ins[11:7];
      s.rs1  = ins[19:15];
      s.rs2  = ins[24:20];
      s.valid = v;
      s.wr   = v && (op inside {OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR})
                 && (s.rd != 5'd0);
      s.use1 = v && (op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR})
                 && (s.rs1 != 5'd0);
      s.use2 = v && (op inside {OP_R, OP_STORE, OP_BRANCH}) && (s.rs2 != 5'd0);
      s.ld   = v && (op == OP_LOAD);
      return s;
   endfunction

   function automatic logic dep(input stage_t prod, input stage_t cons);
      return prod.valid && prod.wr &&
             ((cons.use1 && (cons.rs1 == prod.rd)) || (cons.use2 && (cons.rs2 == prod.rd)));
   endfunction

   stage_t e_q, m_q, w_q;
   stage_t d_dec;
   logic   hz;

   assign d_dec = decode(instr_D, valid_D);

`ifdef HAZARD_FWD_EN
   function automatic logic [1:0] fsel(input stage_t m, input stage_t w,
                                       input logic [4:0] rs, input logic use_rs);
      if (use_rs && m.valid && m.wr && !m.ld && (m.rd == rs))
         return 2'b01;
      else if (use_rs && w.valid && w.wr && (w.rd == rs))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   assign hz     = valid_D && e_q.ld && dep(e_q, d_dec);
   assign fwdA_E = reset ? 2'b00 : fsel(m_q, w_q, e_q.rs1, e_q.use1);
   assign fwdB_E = reset ? 2'b00 : fsel(m_q, w_q, e_q.rs2, e_q.use2);
`else
   // W is not checked: the register file bypasses a same-cycle write
   assign hz     = valid_D && (dep(e_q, d_dec) || dep(m_q, d_dec));
   assign fwdA_E = 2'b00;
   assign fwdB_E = 2'b00;
`endif

   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      freeze  = mem_busy && !reset;
      if (!reset) begin
         if (br_taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
         end else if (hz) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else if (!mem_busy) begin
         w_q <= m_q;
         m_q <= e_q;
         e_q <= flush_E ? '0 : d_dec;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!mem_busy) begin
         if (br_taken_E) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
         end else if (hz) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   // Fields that only the forwarding build consumes, plus unused instruction bits
   logic unused_ok;
   assign unused_ok = ^{instr_D[31:25], instr_D[14:12], e_q, m_q, w_q};

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed per-cycle vectors, expected outputs queued, monitor compares.
`default_nettype none

module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_D;
   logic        valid_D;
   logic        br_taken_E;
   logic        mem_busy;
   logic        stall_F, stall_D, flush_D, flush_E, freeze;
   logic [1:0]  fwdA_E, fwdB_E;
   logic [3:0]  stall_cnt, flush_cnt;

   hazard_unit #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D),
      .br_taken_E(br_taken_E), .mem_busy(mem_busy),
      .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
      .freeze(freeze), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       st_f, st_d, fl_d, fl_e, frz;
      logic [1:0] fa, fb;
      logic [3:0] sc, fc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   logic [31:0] lw_x5, add_x6, addi_x3, add_x4, sub_x7, addi_x0, add_x2;

   // One cycle: drive inputs, queue the expected outputs, advance to just after the edge
   task automatic step(input logic [31:0] ins, input logic v, input logic br, input logic mb,
                       input logic r, input logic st, input logic fd, input logic fe,
                       input logic [1:0] fa, input logic [1:0] fb, input int sc, input int fc);
      exp_t e;
      instr_D    = ins;
      valid_D    = v;
      br_taken_E = br;
      mem_busy   = mb;
      reset      = r;
      e.st_f = st;
      e.st_d = st;
      e.fl_d = fd;
      e.fl_e = fe;
      e.frz  = mb && !r;
      e.fa   = fa;
      e.fb   = fb;
      e.sc   = sc[3:0];
      e.fc   = fc[3:0];
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic bub(input int sc, input int fc);
      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, sc, fc);
   endtask

   // Monitor: outputs are presented every cycle; compare at the falling edge
   initial begin
      exp_t e_exp, e_act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e_exp = sb.pop_front();
            e_act = {stall_F, stall_D, flush_D, flush_E, freeze, fwdA_E, fwdB_E,
                     stall_cnt, flush_cnt};
            total++;
            if (e_act !== e_exp) begin
               bad++;
               $display("FAIL cyc%0d {stF,stD,flD,flE,frz,fa,fb,sc,fc}: act=%b_%b_%b_%b_%b_%b_%b_%h_%h req=%b_%b_%b_%b_%b_%b_%b_%h_%h",
                        cyc, e_act.st_f, e_act.st_d, e_act.fl_d, e_act.fl_e, e_act.frz,
                        e_act.fa, e_act.fb, e_act.sc, e_act.fc,
                        e_exp.st_f, e_exp.st_d, e_exp.fl_d, e_exp.fl_e, e_exp.frz,
                        e_exp.fa, e_exp.fb, e_exp.sc, e_exp.fc);
            end
            cyc++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c2, c5;
      lw_x5   = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'b0000011);
      add_x6  = enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'b0110011);
      addi_x3 = enc(7'h00, 5'd7, 5'd0, 3'd0, 5'd3, 7'b0010011);
      add_x4  = enc(7'h00, 5'd3, 5'd3, 3'd0, 5'd4, 7'b0110011);
      sub_x7  = enc(7'h20, 5'd3, 5'd4, 3'd0, 5'd7, 7'b0110011);
      addi_x0 = enc(7'h00, 5'd1, 5'd0, 3'd0, 5'd0, 7'b0010011);
      add_x2  = enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd2, 7'b0110011);
      c2 = FWD ? 1 : 6;
      c5 = FWD ? 2 : 8;

      reset = 1'b1; instr_D = '0; valid_D = 1'b0; br_taken_E = 1'b0; mem_busy = 1'b0;
      @(posedge clk);
      #1;
      // In reset: everything low even with branch and busy asserted
      step(add_x6, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);

      // Load-use
`ifdef HAZARD_FWD_EN
      step(lw_x5,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      step(add_x6, 1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0);
      step(add_x6, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
      step(32'h0,  0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 0);
      bub(1, 0); bub(1, 0);
`else
      step(lw_x5,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      step(add_x6, 1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0);
      step(add_x6, 1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 1, 0);
      step(add_x6, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 0);
      bub(2, 0); bub(2, 0); bub(2, 0);
`endif

      // ALU chain
`ifdef HAZARD_FWD_EN
      step(addi_x3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
      step(add_x4,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
      step(sub_x7,  1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 0);
      step(32'h0,   0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 1, 0);
      bub(1, 0); bub(1, 0);
`else
      step(addi_x3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 0);
      step(add_x4,  1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2, 0);
      step(add_x4,  1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 3, 0);
      step(add_x4,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4, 0);
      step(sub_x7,  1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 4, 0);
      step(sub_x7,  1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 5, 0);
      step(sub_x7,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 6, 0);
      bub(6, 0); bub(6, 0); bub(6, 0);
`endif

      // x0 destination never hazards or forwards
      step(addi_x0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, c2, 0);
      step(add_x2,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, c2, 0);
      bub(c2, 0); bub(c2, 0); bub(c2, 0);

      // Branch taken while D holds a load-use dependent: flush wins, no stall counted
      step(lw_x5,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, c2, 0);
      step(add_x6, 1, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, c2, 0);
      bub(c2, 1); bub(c2, 1); bub(c2, 1);

      // Freeze for 3 cycles in the middle of a load-use stall
      step(lw_x5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, c2, 1);
      for (int i = 0; i < 3; i++)
         step(add_x6, 1, 0, 1, 0, 1, 0, 1, 2'b00, 2'b00, c2, 1);
      step(add_x6, 1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, c2, 1);
`ifdef HAZARD_FWD_EN
      step(add_x6, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 1);
      step(32'h0,  0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2, 1);
      bub(2, 1); bub(2, 1);
`else
      step(add_x6, 1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 7, 1);
      step(add_x6, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 8, 1);
      bub(8, 1); bub(8, 1); bub(8, 1);
`endif

      // Reset asserted mid-stall drops outputs at once and clears counters
      step(lw_x5,  1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, c5, 1);
      step(add_x6, 1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, c5, 1);
      step(add_x6, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      step(add_x6, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
      bub(0, 0);

      // Branch held during freeze is not counted; then flush counter saturates at 15
      step(32'h0, 0, 1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
      step(32'h0, 0, 1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
      for (int k = 0; k < 18; k++)
         step(32'h0, 0, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, (k > 15) ? 15 : k);
      bub(0, 15);

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: act=%0d pending req=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
